// File: rtl/mul_div_unit_pkg.sv
// Shared constants and helpers for the HI/LO multiply/divide engine.
// Op codes and FSM encodings are fixed values the pipeline decoder also relies on.
package mul_div_unit_pkg;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? 32'd0 - v : v;
    endfunction

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? 32'd0 - v : v;
    endfunction

endpackage

// File: rtl/mul_div_unit_div_core.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per cycle, 32 steps.
// The dividend shifts out of the quotient register as quotient bits shift in.
module mul_div_unit_div_core
    import mul_div_unit_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic        i_start,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_last,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);

    logic        r_active;
    logic [4:0]  r_count;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_divisor;

    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_fits;

    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {1'b0, r_divisor};
    assign w_fits  = ~w_diff[32];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_active  <= 1'b0;
            r_count   <= 5'd0;
            r_rem     <= 32'd0;
            r_quo     <= 32'd0;
            r_divisor <= 32'd0;
        end else if (i_flush) begin
            r_active <= 1'b0;
            r_count  <= 5'd0;
        end else if (i_start) begin
            r_active  <= 1'b1;
            r_count   <= 5'd0;
            r_rem     <= 32'd0;
            r_quo     <= i_dividend;
            r_divisor <= i_divisor;
        end else if (r_active) begin
            r_rem   <= w_fits ? w_diff[31:0] : w_shift[31:0];
            r_quo   <= {r_quo[30:0], w_fits};
            r_count <= r_count + 5'd1;
            if (r_count == 5'd31) begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_last      = r_active && (r_count == 5'd31);
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/mul_div_unit.sv
// Execute-stage multiply/divide engine driving one-cycle HI/LO write pulses.
// Multiply completes in one MUL cycle; divide runs 32 DIV steps then a FIX sign-correction cycle.
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        hi_write_enable_o,
    output logic [31:0] hi_write_data_o,
    output logic        lo_write_enable_o,
    output logic [31:0] lo_write_data_o
);

    logic [1:0]  r_state;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic        r_signed;
    logic        r_div_zero;
    logic        r_busy;
    logic        r_hi_we;
    logic [31:0] r_hi_wd;
    logic        r_lo_we;
    logic [31:0] r_lo_wd;

    logic [1:0]  w_state_next;
    logic [31:0] w_op_a_next;
    logic [31:0] w_op_b_next;
    logic        w_signed_next;
    logic        w_div_zero_next;
    logic        w_hi_we_next;
    logic [31:0] w_hi_wd_next;
    logic        w_lo_we_next;
    logic [31:0] w_lo_wd_next;

    logic        w_div_start;
    logic        w_div_last;
    logic [31:0] w_dividend;
    logic [31:0] w_divisor;
    logic [31:0] w_quotient;
    logic [31:0] w_remainder;
    logic [31:0] w_quo_fixed;
    logic [31:0] w_rem_fixed;

    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    hilo_t       w_prod;

    // Low 64 bits of the product of sign/zero-extended operands covers both MULT and MULTU.
    assign w_a_ext = {{32{r_signed & r_op_a[31]}}, r_op_a};
    assign w_b_ext = {{32{r_signed & r_op_b[31]}}, r_op_b};
    assign w_prod  = w_a_ext * w_b_ext;

    assign w_dividend = abs32(operand_a_i, op_i == OP_DIV);
    assign w_divisor  = abs32(operand_b_i, op_i == OP_DIV);

    assign w_quo_fixed = neg_if(w_quotient, r_signed & (r_op_a[31] ^ r_op_b[31]));
    assign w_rem_fixed = neg_if(w_remainder, r_signed & r_op_a[31]);

    mul_div_unit_div_core u_div_core (
        .i_clk       (clock_i),
        .i_rst       (reset_i),
        .i_flush     (flush_i),
        .i_start     (w_div_start),
        .i_dividend  (w_dividend),
        .i_divisor   (w_divisor),
        .o_last      (w_div_last),
        .o_quotient  (w_quotient),
        .o_remainder (w_remainder)
    );

    always_comb begin
        w_state_next    = r_state;
        w_op_a_next     = r_op_a;
        w_op_b_next     = r_op_b;
        w_signed_next   = r_signed;
        w_div_zero_next = r_div_zero;
        w_hi_we_next    = 1'b0;
        w_hi_wd_next    = r_hi_wd;
        w_lo_we_next    = 1'b0;
        w_lo_wd_next    = r_lo_wd;
        w_div_start     = 1'b0;

        if (flush_i) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        case (op_i)
                            OP_MTHI: begin
                                w_hi_we_next = 1'b1;
                                w_hi_wd_next = operand_a_i;
                            end
                            OP_MTLO: begin
                                w_lo_we_next = 1'b1;
                                w_lo_wd_next = operand_a_i;
                            end
                            OP_MULT, OP_MULTU: begin
                                w_op_a_next   = operand_a_i;
                                w_op_b_next   = operand_b_i;
                                w_signed_next = (op_i == OP_MULT);
                                w_state_next  = ST_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                w_op_a_next     = operand_a_i;
                                w_op_b_next     = operand_b_i;
                                w_signed_next   = (op_i == OP_DIV);
                                w_div_zero_next = (operand_b_i == 32'd0);
                                if (operand_b_i == 32'd0) begin
                                    w_state_next = ST_FIX;
                                end else begin
                                    w_div_start  = 1'b1;
                                    w_state_next = ST_DIV;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    w_hi_we_next = 1'b1;
                    w_hi_wd_next = w_prod.hi;
                    w_lo_we_next = 1'b1;
                    w_lo_wd_next = w_prod.lo;
                    w_state_next = ST_IDLE;
                end
                ST_DIV: begin
                    if (w_div_last) begin
                        w_state_next = ST_FIX;
                    end
                end
                ST_FIX: begin
                    w_hi_we_next = 1'b1;
                    w_lo_we_next = 1'b1;
                    w_hi_wd_next = r_div_zero ? r_op_a : w_rem_fixed;
                    w_lo_wd_next = r_div_zero ? 32'hFFFF_FFFF : w_quo_fixed;
                    w_state_next = ST_IDLE;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= ST_IDLE;
            r_op_a     <= 32'd0;
            r_op_b     <= 32'd0;
            r_signed   <= 1'b0;
            r_div_zero <= 1'b0;
            r_busy     <= 1'b0;
            r_hi_we    <= 1'b0;
            r_hi_wd    <= 32'd0;
            r_lo_we    <= 1'b0;
            r_lo_wd    <= 32'd0;
        end else begin
            r_state    <= w_state_next;
            r_op_a     <= w_op_a_next;
            r_op_b     <= w_op_b_next;
            r_signed   <= w_signed_next;
            r_div_zero <= w_div_zero_next;
            r_busy     <= (w_state_next != ST_IDLE);
            r_hi_we    <= w_hi_we_next;
            r_hi_wd    <= w_hi_wd_next;
            r_lo_we    <= w_lo_we_next;
            r_lo_wd    <= w_lo_wd_next;
        end
    end

    assign busy_o            = r_busy;
    assign hi_write_enable_o = r_hi_we;
    assign hi_write_data_o   = r_hi_wd;
    assign lo_write_enable_o = r_lo_we;
    assign lo_write_data_o   = r_lo_wd;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized ops
// compared against an arithmetic reference model.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        flush;
    logic        busy;
    logic        hwe;
    logic [31:0] hwd;
    logic        lwe;
    logic [31:0] lwd;

    int n_checks;
    int n_pass;

    mul_div_unit dut (
        .clock_i           (clk),
        .reset_i           (rst),
        .start_i           (start),
        .op_i              (op),
        .operand_a_i       (opa),
        .operand_b_i       (opb),
        .flush_i           (flush),
        .busy_o            (busy),
        .hi_write_enable_o (hwe),
        .hi_write_data_o   (hwd),
        .lo_write_enable_o (lwe),
        .lo_write_data_o   (lwd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Expected architectural result and latency (cycle of the write pulse; 0 = ignored op).
    task automatic model(input logic [2:0] m_op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output int lat,
                         output bit wh, output bit wl);
        longint sa, sb, p, q, r;
        longint unsigned ua, ub, up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        eh = 32'd0; el = 32'd0; lat = 0; wh = 1'b0; wl = 1'b0;
        case (m_op)
            OP_MTHI: begin wh = 1'b1; eh = a; lat = 1; end
            OP_MTLO: begin wl = 1'b1; el = a; lat = 1; end
            OP_MULT: begin
                p = sa * sb;
                eh = p[63:32]; el = p[31:0]; wh = 1'b1; wl = 1'b1; lat = 2;
            end
            OP_MULTU: begin
                up = ua * ub;
                eh = up[63:32]; el = up[31:0]; wh = 1'b1; wl = 1'b1; lat = 2;
            end
            OP_DIV, OP_DIVU: begin
                wh = 1'b1; wl = 1'b1;
                if (b == 32'd0) begin
                    el = 32'hFFFF_FFFF; eh = a; lat = 2;
                end else begin
                    lat = 34;
                    if (m_op == OP_DIV) begin
                        q = sa / sb; r = sa % sb;
                    end else begin
                        q = longint'(ua / ub); r = longint'(ua % ub);
                    end
                    el = q[31:0]; eh = r[31:0];
                end
            end
            default: ;
        endcase
    endtask

    // Issue one op and follow it cycle by cycle until its pulse; ends inside the pulse cycle.
    task automatic run_op(input logic [2:0] r_op, input logic [31:0] a, input logic [31:0] b,
                          input bit gap);
        logic [31:0] eh, el;
        int lat;
        bit wh, wl;
        model(r_op, a, b, eh, el, lat, wh, wl);
        @(negedge clk);
        start = 1'b1; op = r_op; opa = a; opb = b;
        @(posedge clk); #1;
        start = 1'b0;
        if (lat == 0) begin
            for (int t = 1; t <= 3; t++) begin
                check_eq("ignored_busy", busy, 1'b0);
                check_eq("ignored_we", {hwe, lwe}, 2'b00);
                if (t < 3) begin @(posedge clk); #1; end
            end
        end else begin
            for (int t = 1; t <= lat; t++) begin
                check_eq("busy", busy, t < lat);
                check_eq("we", {hwe, lwe}, (t == lat) ? {wh, wl} : 2'b00);
                if (t == lat && wh) check_eq("hi_data", hwd, eh);
                if (t == lat && wl) check_eq("lo_data", lwd, el);
                if (t < lat) begin @(posedge clk); #1; end
            end
        end
        if (gap) begin
            @(posedge clk); #1;
            check_eq("gap_busy", busy, 1'b0);
            check_eq("gap_we", {hwe, lwe}, 2'b00);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n_hi;
        n_checks = 0;
        n_pass = 0;
        rst = 1'b1; start = 1'b0; op = OP_NONE; opa = 32'd0; opb = 32'd0; flush = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_hwe", hwe, 1'b0);
        check_eq("rst_lwe", lwe, 1'b0);
        check_eq("rst_hwd", hwd, 32'd0);
        check_eq("rst_lwd", lwd, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1);
        run_op(OP_DIVU, 32'd100, 32'd7, 1'b1);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op(OP_DIVU, 32'h0000_1234, 32'd0, 1'b1);
        run_op(OP_MTHI, 32'h1234_5678, 32'd0, 1'b1);
        run_op(OP_NONE, 32'h1111_1111, 32'd3, 1'b0);
        run_op(3'd7, 32'h2222_2222, 32'd3, 1'b0);

        // Flush a divide at T10: idle at T11, no pulse, then an immediate multiply.
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; opa = 32'd1000; opb = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 1; t <= 11; t++) begin
            if (t == 10) flush = 1'b1;
            check_eq("flush_busy", busy, t <= 10);
            check_eq("flush_we", {hwe, lwe}, 2'b00);
            if (t < 11) begin @(posedge clk); #1; end
        end
        flush = 1'b0;
        run_op(OP_MULTU, 32'd3, 32'd5, 1'b1);

        // start held high through a divide with a different op: only the divide writes.
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; opa = 32'd100; opb = 32'd7;
        @(posedge clk); #1;
        op = OP_MTHI; opa = 32'hDEAD_0000;
        n_hi = 0;
        for (int t = 1; t <= 36; t++) begin
            check_eq("hold_busy", busy, t < 34);
            check_eq("hold_we", {hwe, lwe}, (t == 34) ? 2'b11 : 2'b00);
            if (hwe) n_hi++;
            if (t == 34) begin
                check_eq("hold_hi", hwd, 32'd2);
                check_eq("hold_lo", lwd, 32'd14);
            end
            if (t == 33) start = 1'b0;
            if (t < 36) begin @(posedge clk); #1; end
        end
        check_eq("hold_pulses", n_hi, 1);

        // Reset mid-divide.
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; opa = 32'd100; opb = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_hwe", hwe, 1'b0);
        check_eq("mid_rst_lwe", lwe, 1'b0);
        check_eq("mid_rst_hwd", hwd, 32'd0);
        check_eq("mid_rst_lwd", lwd, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk); #1;
            check_eq("post_rst_quiet", {busy, hwe, lwe}, 3'b000);
        end
        run_op(OP_MTLO, 32'hA5A5_A5A5, 32'd0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] r_op;
            r_op = 3'($urandom_range(0, 7));
            run_op(r_op, pick(), pick(), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
